// File: rtl/siren_driver.sv
// siren_driver: decodes the 3-bit siren code into alarm wail / chirp tone on a speaker pin
module siren_driver #(
  parameter int TONE_A_DIV       = 25000,
  parameter int TONE_B_DIV       = 37500,
  parameter int SWAP_CYCLES      = 50000000,
  parameter int CHIRP_ON_CYCLES  = 10000000,
  parameter int CHIRP_OFF_CYCLES = 90000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] siren,
  output logic       speaker,
  output logic       siren_active,
  output logic       code_error
);
  localparam int TMAX = TONE_A_DIV > TONE_B_DIV ? TONE_A_DIV : TONE_B_DIV;
  localparam int CMAX = CHIRP_ON_CYCLES > CHIRP_OFF_CYCLES ? CHIRP_ON_CYCLES : CHIRP_OFF_CYCLES;
  localparam int DMAX = SWAP_CYCLES > CMAX ? SWAP_CYCLES : CMAX;
  localparam int TW = $clog2(TMAX);
  localparam int DW = $clog2(DMAX);
  typedef enum logic [2:0] {IDLE, ALARM_A, ALARM_B, CHIRP_ON, CHIRP_OFF} state_t;
  typedef enum logic [1:0] {M_OFF, M_ALARM, M_CHIRP} mode_t;
  state_t state, entry, next_timed;
  mode_t mode, cur_mode;
  logic [TW-1:0] tone_cnt, tone_top;
  logic [DW-1:0] dur_cnt, dur_top;
  logic timed, toned, tone_wrap;
  always_comb begin
    mode = siren == 3'b001 ? M_ALARM : siren == 3'b100 ? M_CHIRP : M_OFF;
    cur_mode = state == IDLE ? M_OFF : (state == ALARM_A || state == ALARM_B) ? M_ALARM : M_CHIRP;
    entry = mode == M_ALARM ? ALARM_A : mode == M_CHIRP ? CHIRP_ON : IDLE;
    next_timed = state == ALARM_A ? ALARM_B : state == ALARM_B ? ALARM_A : state == CHIRP_ON ? CHIRP_OFF : CHIRP_ON;
    tone_top = state == ALARM_B ? TW'(TONE_B_DIV - 1) : TW'(TONE_A_DIV - 1);
    dur_top = (state == ALARM_A || state == ALARM_B) ? DW'(SWAP_CYCLES - 1) :
              state == CHIRP_ON ? DW'(CHIRP_ON_CYCLES - 1) : DW'(CHIRP_OFF_CYCLES - 1);
    timed = state != IDLE;
    toned = state == ALARM_A || state == ALARM_B || state == CHIRP_ON;
    tone_wrap = tone_cnt == tone_top;
  end
  // Mode change outranks duration expiry, which outranks the tone toggle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tone_cnt     <= '0;
      dur_cnt      <= '0;
      speaker      <= 1'b0;
      siren_active <= 1'b0;
      code_error   <= 1'b0;
    end else begin
      code_error   <= !(siren == 3'b000 || siren == 3'b001 || siren == 3'b100);
      siren_active <= mode != M_OFF;
      if (mode != cur_mode) begin
        state    <= entry;
        tone_cnt <= '0;
        dur_cnt  <= '0;
        speaker  <= 1'b0;
      end else if (timed && dur_cnt == dur_top) begin
        state    <= next_timed;
        tone_cnt <= '0;
        dur_cnt  <= '0;
        speaker  <= 1'b0;
      end else if (timed) begin
        dur_cnt <= dur_cnt + 1'b1;
        if (toned) begin
          tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
          speaker  <= speaker ^ tone_wrap;
        end
      end
    end
  end
endmodule
